lc3_control_unit: RTL

Moore-style fetch/decode/execute controller for the LC-3 datapath. It sequences register loads, bus gates, mux selects and SRAM strobes for each instruction. It sits directly downstream of the branch-enable register: it pulses `LD_BEN` during decode and consumes the registered `BEN` one state later to resolve conditional branches.

---
 rtl/lc3_control_unit.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/lc3_control_unit.sv
// ---------------------------------------------------------------------------
// lc3_control_unit
//
// Moore fetch/decode/execute sequencer for the LC-3 datapath. It drives the
// register load enables, the bus gates, the mux selects and the active-low
// SRAM strobes. The BEN register is loaded during decode (LD_BEN) and its
// output is consumed one state later to resolve conditional branches.
//
// Every control output comes straight from a flop. The flops are loaded from
// the decode of the *next* state, so the outputs track the current state
// with no combinational path from any input.
//
// Parameter
//   MEM_WAIT  extra cycles each memory state is held (0..7, default 2)
//
// Optional build
//   LC3_PAUSE_EN  adds the PAUSE states P1/P2 for opcode 1101. Without this
//                 macro, opcode 1101 is a NOP.
//
// Ports
//   Clk, Reset            clock; asynchronous active-low reset
//   Run                   level-sensitive run enable (0 -> HALTED)
//   Continue              releases a PAUSE (LC3_PAUSE_EN builds only)
//   Opcode, IR_5, IR_11   instruction fields IR[15:12], IR[5], IR[11]
//   BEN                   registered branch enable
//   LD_*                  register load enables
//   Gate*                 bus drivers (at most one is high at a time)
//   PCMUX                 00 PC+1, 01 bus, 10 address adder
//   DRMUX                 0 IR[11:9], 1 R7
//   SR1MUX                0 IR[11:9], 1 IR[8:6]
//   SR2MUX                0 register SR2, 1 sign-extended imm5
//   ADDR1MUX              0 PC, 1 SR1 (BaseR)
//   ADDR2MUX              00 zero, 01 off6, 10 off9, 11 off11
//   ALUK                  00 ADD, 01 AND, 10 NOT, 11 PASSA
//   Mem_OE, Mem_WE        active-low SRAM strobes
// ---------------------------------------------------------------------------
module lc3_control_unit #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    localparam logic [2:0] WAIT_LOAD = MEM_WAIT[2:0];

    typedef enum logic [4:0] {
        HALTED, S18, S33, S35, S32,
        S01, S05, S09, S00, S22, S12,
        S04, S21, S20,
        S06, S25, S27,
        S07, S23, S16
`ifdef LC3_PAUSE_EN
        , P1, P2
`endif
    } state_e;

    typedef struct packed {
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_ir;
        logic       ld_ben;
        logic       ld_cc;
        logic       ld_reg;
        logic       ld_pc;
        logic       gate_pc;
        logic       gate_mdr;
        logic       gate_alu;
        logic       gate_marmux;
        logic [1:0] pcmux;
        logic       drmux;
        logic       sr1mux;
        logic       sr2mux;
        logic       addr1mux;
        logic [1:0] addr2mux;
        logic [1:0] aluk;
        logic       mem_oe_n;
        logic       mem_we_n;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{mem_oe_n: 1'b1, mem_we_n: 1'b1, default: '0};

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    ctrl_t      ctrl_q, ctrl_d;

`ifndef LC3_PAUSE_EN
    logic unused_continue;
    assign unused_continue = Continue;
`endif

    // Control word for a state. The ADD/AND operand select follows IR_5 at
    // the edge that enters S01/S05; since it is registered, it is stable for
    // the whole state.
    function automatic ctrl_t decode(input state_e s, input logic ir5);
        ctrl_t c;
        c = CTRL_IDLE;
        case (s)
            S18: begin c.ld_mar = 1'b1; c.ld_pc = 1'b1; c.gate_pc = 1'b1; end
            S33, S25: begin c.mem_oe_n = 1'b0; c.ld_mdr = 1'b1; end
            S35: begin c.gate_mdr = 1'b1; c.ld_ir = 1'b1; end
            S32: c.ld_ben = 1'b1;
            S01, S05: begin
                c.ld_reg   = 1'b1;
                c.ld_cc    = 1'b1;
                c.gate_alu = 1'b1;
                c.sr1mux   = 1'b1;
                c.sr2mux   = ir5;
                c.aluk     = (s == S05) ? 2'b01 : 2'b00;
            end
            S09: begin
                c.ld_reg = 1'b1; c.ld_cc = 1'b1; c.gate_alu = 1'b1;
                c.sr1mux = 1'b1; c.aluk = 2'b10;
            end
            S22: begin c.ld_pc = 1'b1; c.pcmux = 2'b10; c.addr2mux = 2'b10; end
            S21: begin c.ld_pc = 1'b1; c.pcmux = 2'b10; c.addr2mux = 2'b11; end
            // JMP and JSRR both form BaseR + 0 in the address adder.
            S12, S20: begin
                c.ld_pc = 1'b1; c.pcmux = 2'b10; c.addr1mux = 1'b1; c.sr1mux = 1'b1;
            end
            S04: begin c.gate_pc = 1'b1; c.ld_reg = 1'b1; c.drmux = 1'b1; end
            S06, S07: begin
                c.gate_marmux = 1'b1; c.ld_mar = 1'b1;
                c.addr1mux = 1'b1; c.addr2mux = 2'b01; c.sr1mux = 1'b1;
            end
            S27: begin c.gate_mdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1; end
            // Store source register passes through the ALU onto the bus.
            S23: begin c.gate_alu = 1'b1; c.ld_mdr = 1'b1; c.aluk = 2'b11; end
            S16: c.mem_we_n = 1'b0;
            default: c = CTRL_IDLE;
        endcase
        return c;
    endfunction

    always_comb begin
        // NOTE: every variable gets a default first so no path through the
        // case statements leaves it unassigned, which would infer a latch.
        state_d = state_q;
        cnt_d   = (cnt_q != 3'd0) ? cnt_q - 3'd1 : 3'd0;

        if (!Run) begin
            // Dropping Run abandons any memory wait in progress.
            state_d = HALTED;
            cnt_d   = 3'd0;
        end else begin
            case (state_q)
                HALTED: state_d = S18;
                S18:    state_d = S33;
                S33:    if (cnt_q == 3'd0) state_d = S35;
                S35:    state_d = S32;
                S32: begin
                    case (Opcode)
                        4'b0001: state_d = S01;
                        4'b0101: state_d = S05;
                        4'b1001: state_d = S09;
                        4'b0000: state_d = S00;
                        4'b1100: state_d = S12;
                        4'b0100: state_d = S04;
                        4'b0110: state_d = S06;
                        4'b0111: state_d = S07;
`ifdef LC3_PAUSE_EN
                        4'b1101: state_d = P1;
`endif
                        default: state_d = S18;
                    endcase
                end
                S00:    state_d = BEN ? S22 : S18;
                S04:    state_d = IR_11 ? S21 : S20;
                S06:    state_d = S25;
                S25:    if (cnt_q == 3'd0) state_d = S27;
                S07:    state_d = S23;
                S23:    state_d = S16;
                S16:    if (cnt_q == 3'd0) state_d = S18;
`ifdef LC3_PAUSE_EN
                P1:     if (Continue) state_d = P2;
                P2:     if (!Continue) state_d = S18;
`endif
                default: state_d = S18;
            endcase

            // The wait counter is armed on entry to a memory state.
            if ((state_d != state_q) && (state_d inside {S33, S25, S16})) begin
                cnt_d = WAIT_LOAD;
            end
        end

        ctrl_d = decode(state_d, IR_5);
    end

    // NOTE: the registered control word is reset to the idle pattern (strobes
    // high) so the SRAM is released the instant Reset falls, not at a clock.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= HALTED;
            cnt_q   <= 3'd0;
            ctrl_q  <= CTRL_IDLE;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign LD_MAR     = ctrl_q.ld_mar;
    assign LD_MDR     = ctrl_q.ld_mdr;
    assign LD_IR      = ctrl_q.ld_ir;
    assign LD_BEN     = ctrl_q.ld_ben;
    assign LD_CC      = ctrl_q.ld_cc;
    assign LD_REG     = ctrl_q.ld_reg;
    assign LD_PC      = ctrl_q.ld_pc;
    assign GatePC     = ctrl_q.gate_pc;
    assign GateMDR    = ctrl_q.gate_mdr;
    assign GateALU    = ctrl_q.gate_alu;
    assign GateMARMUX = ctrl_q.gate_marmux;
    assign PCMUX      = ctrl_q.pcmux;
    assign DRMUX      = ctrl_q.drmux;
    assign SR1MUX     = ctrl_q.sr1mux;
    assign SR2MUX     = ctrl_q.sr2mux;
    assign ADDR1MUX   = ctrl_q.addr1mux;
    assign ADDR2MUX   = ctrl_q.addr2mux;
    assign ALUK       = ctrl_q.aluk;
    assign Mem_OE     = ctrl_q.mem_oe_n;
    assign Mem_WE     = ctrl_q.mem_we_n;

endmodule
